// File: rtl/framebuf_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : framebuf_scan_ctrl
// Purpose  : Scan-out sequencer for a double-buffered voxel frame buffer.
//            It reads one bank layer by layer and serialises each word to the
//            LED column chain, then drives blanking, latch and layer select.
// Options  : FRAMEBUF_SCAN_DIM_PWM_EN adds a brightness input that
//            PWM-dims led_oe_n.
// Revision : 1.0 - initial release
// ============================================================================
module framebuf_scan_ctrl #(
  parameter int ADDR_W          = 13,
  parameter int DATA_W          = 16,
  parameter int NUM_LAYERS      = 16,
  parameter int WORDS_PER_LAYER = 256,
  parameter int SCLK_DIV        = 4,
  parameter int BLANK_CYCLES    = 64
) (
`ifdef FRAMEBUF_SCAN_DIM_PWM_EN
  input  logic [7:0]                      brightness,
`endif
  input  logic                            clk,
  input  logic                            reset_n,
  input  logic                            enable,
  output logic [ADDR_W-1:0]               mem_address,
  output logic                            mem_chipselect,
  input  logic [DATA_W-1:0]               mem_readdata,
  input  logic                            swap_req,
  output logic                            swap_ack,
  output logic                            front_bank,
  output logic                            led_sclk,
  output logic                            led_sdata,
  output logic                            led_latch,
  output logic                            led_oe_n,
  output logic [$clog2(NUM_LAYERS)-1:0]   layer_sel,
  output logic                            frame_done
);

  localparam int c_LAYER_W = $clog2(NUM_LAYERS);
  localparam int c_WORD_W  = $clog2(WORDS_PER_LAYER);
  localparam int c_BIT_W   = $clog2(DATA_W);
  localparam int c_DIV_W   = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam int c_BLANK_W = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;

  localparam logic [c_LAYER_W-1:0] c_LAYER_LAST = c_LAYER_W'(NUM_LAYERS - 1);
  localparam logic [c_WORD_W-1:0]  c_WORD_LAST  = c_WORD_W'(WORDS_PER_LAYER - 1);
  localparam logic [c_BIT_W-1:0]   c_BIT_LAST   = c_BIT_W'(DATA_W - 1);
  localparam logic [c_DIV_W-1:0]   c_DIV_LAST   = c_DIV_W'(SCLK_DIV - 1);
  localparam logic [c_BLANK_W-1:0] c_BLANK_LAST = c_BLANK_W'(BLANK_CYCLES - 1);

  localparam logic [2:0] c_IDLE      = 3'd0;
  localparam logic [2:0] c_FETCH     = 3'd1;
  localparam logic [2:0] c_CAPTURE   = 3'd2;
  localparam logic [2:0] c_SHIFT     = 3'd3;
  localparam logic [2:0] c_BLANK     = 3'd4;
  localparam logic [2:0] c_LATCH     = 3'd5;
  localparam logic [2:0] c_FRAME_END = 3'd6;

  logic [2:0]           r_state;
  logic [2:0]           w_next;
  logic                 r_front;
  logic [c_LAYER_W-1:0] r_layer;
  logic [c_LAYER_W-1:0] r_layer_sel;
  logic [c_WORD_W-1:0]  r_word;
  logic [DATA_W-1:0]    r_shreg;
  logic [c_BIT_W-1:0]   r_bit_cnt;
  logic [c_DIV_W-1:0]   r_div;
  logic                 r_sclk;
  logic [c_BLANK_W-1:0] r_blank;
  logic                 r_oe_n;

  logic w_div_wrap;
  logic w_word_last;
  logic w_layer_last;
  logic w_bit_done;
  logic w_blank_done;

  assign w_div_wrap   = (r_div == c_DIV_LAST);
  assign w_word_last  = (r_word == c_WORD_LAST);
  assign w_layer_last = (r_layer == c_LAYER_LAST);
  // Last bit ends on the falling sclk edge of bit 0.
  assign w_bit_done   = w_div_wrap && r_sclk && (r_bit_cnt == '0);
  assign w_blank_done = (r_blank == c_BLANK_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE:      if (enable) w_next = c_FETCH;
      c_FETCH:     w_next = c_CAPTURE;
      c_CAPTURE:   w_next = c_SHIFT;
      c_SHIFT:     if (w_bit_done) w_next = w_word_last ? c_BLANK : c_FETCH;
      c_BLANK:     if (w_blank_done) w_next = c_LATCH;
      c_LATCH:     w_next = w_layer_last ? c_FRAME_END : c_FETCH;
      c_FRAME_END: w_next = enable ? c_FETCH : c_IDLE;
      default:     w_next = c_IDLE;
    endcase
  end

  always_comb begin
    mem_chipselect = (r_state == c_FETCH);
    led_latch      = (r_state == c_LATCH);
    frame_done     = (r_state == c_FRAME_END);
    swap_ack       = (r_state == c_FRAME_END) && swap_req;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_front     <= 1'b0;
      r_layer     <= '0;
      r_layer_sel <= '0;
      r_word      <= '0;
      r_shreg     <= '0;
      r_bit_cnt   <= '0;
      r_div       <= '0;
      r_sclk      <= 1'b0;
      r_blank     <= '0;
      r_oe_n      <= 1'b1;
    end else begin
      r_blank <= '0;
      case (r_state)
        c_IDLE: begin
          r_layer <= '0;
          r_word  <= '0;
        end
        c_CAPTURE: begin
          r_shreg   <= mem_readdata;
          r_bit_cnt <= c_BIT_LAST;
          r_div     <= '0;
          r_sclk    <= 1'b0;
        end
        c_SHIFT: begin
          if (w_div_wrap) begin
            r_div  <= '0;
            r_sclk <= ~r_sclk;
            if (r_sclk) begin
              r_shreg   <= {r_shreg[DATA_W-2:0], 1'b0};
              r_bit_cnt <= r_bit_cnt - c_BIT_W'(1);
              if ((r_bit_cnt == '0) && !w_word_last) r_word <= r_word + c_WORD_W'(1);
            end
          end else begin
            r_div <= r_div + c_DIV_W'(1);
          end
        end
        c_BLANK: r_blank <= r_blank + c_BLANK_W'(1);
        c_LATCH: begin
          r_layer_sel <= r_layer;
          r_word      <= '0;
          if (!w_layer_last) r_layer <= r_layer + c_LAYER_W'(1);
        end
        c_FRAME_END: begin
          r_layer <= '0;
          if (swap_req) r_front <= ~r_front;
        end
        default: ;
      endcase

      // The latched layer stays lit while the next one shifts in.
      if ((w_next == c_BLANK) || (w_next == c_IDLE)) begin
        r_oe_n <= 1'b1;
      end else if (r_state == c_LATCH) begin
        r_oe_n <= 1'b0;
      end
    end
  end

  assign mem_address = {r_front, r_layer, r_word};
  assign front_bank  = r_front;
  assign led_sclk    = r_sclk;
  assign led_sdata   = r_shreg[DATA_W-1];
  assign layer_sel   = r_layer_sel;

`ifdef FRAMEBUF_SCAN_DIM_PWM_EN
  logic [7:0] r_pwm_cnt;
  logic [7:0] r_bright;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm_cnt <= '0;
      r_bright  <= '0;
    end else begin
      r_pwm_cnt <= r_pwm_cnt + 8'd1;
      if (r_state == c_FRAME_END) r_bright <= brightness;
    end
  end

  assign led_oe_n = r_oe_n | (r_pwm_cnt >= r_bright);
`else
  assign led_oe_n = r_oe_n;
`endif

endmodule
`default_nettype wire

// File: tb/tb_framebuf_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_framebuf_scan_ctrl
// Purpose  : Directed bench for framebuf_scan_ctrl on a reduced geometry
//            (4 layers x 4 words, SCLK_DIV=4, BLANK_CYCLES=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_framebuf_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic [4:0]  mem_address;
  logic        mem_chipselect;
  logic [15:0] mem_readdata;
  logic        swap_req;
  logic        swap_ack;
  logic        front_bank;
  logic        led_sclk;
  logic        led_sdata;
  logic        led_latch;
  logic        led_oe_n;
  logic [1:0]  layer_sel;
  logic        frame_done;

  framebuf_scan_ctrl #(
    .ADDR_W(5), .DATA_W(16), .NUM_LAYERS(4), .WORDS_PER_LAYER(4),
    .SCLK_DIV(4), .BLANK_CYCLES(4)
  ) dut (
`ifdef FRAMEBUF_SCAN_DIM_PWM_EN
    .brightness(8'd255),
`endif
    .clk(clk), .reset_n(reset_n), .enable(enable),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect),
    .mem_readdata(mem_readdata), .swap_req(swap_req), .swap_ack(swap_ack),
    .front_bank(front_bank), .led_sclk(led_sclk), .led_sdata(led_sdata),
    .led_latch(led_latch), .led_oe_n(led_oe_n), .layer_sel(layer_sel),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Address-derived words, asymmetric so bit-order errors are visible.
  logic [15:0] ram [32];
  always_ff @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  int n_tests = 0;
  int n_fail  = 0;
  int k;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    k++;
  endtask

  function automatic logic [14:0] pack_all();
    return {mem_address, mem_chipselect, swap_ack, front_bank, led_sclk, led_sdata,
            led_latch, led_oe_n, layer_sel, frame_done};
  endfunction

  localparam logic [14:0] c_RST_EXP = {5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0};

  typedef struct {
    int         k;
    logic [4:0] addr;
    logic       cs, sclk, sdata, latch, oe_n;
    logic [1:0] ls;
    logic       fd;
  } vec_t;

  localparam int NV = 17;
  vec_t vt [NV];

  // Scoreboard: rebuilds each shifted word and matches it against the fetch.
  logic       sb_en = 1'b0;
  logic [4:0] addr_q [$];
  logic [1:0] ls_log [$];
  int         latch_cnt = 0;
  int         fd_cnt = 0;
  int         sb_words = 0;

  initial begin
    logic        prev_sclk;
    logic        prev_latch;
    logic [15:0] acc;
    int          nbits;
    logic [4:0]  a;
    prev_sclk = 1'b0; prev_latch = 1'b0; acc = '0; nbits = 0;
    forever begin
      @(negedge clk);
      if (sb_en) begin
        if (mem_chipselect) addr_q.push_back(mem_address);
        if (led_sclk && !prev_sclk) begin
          acc = {acc[14:0], led_sdata};
          nbits++;
          if (nbits == 16) begin
            nbits = 0;
            sb_words++;
            if (addr_q.size() == 0) begin
              chk("sb_underflow", 32'd0, 32'd1);
            end else begin
              a = addr_q.pop_front();
              chk($sformatf("sb_word_a%0h", a), {16'd0, acc}, {16'd0, ram[a]});
            end
          end
        end
        if (prev_latch) ls_log.push_back(layer_sel);
        if (led_latch) latch_cnt++;
        if (frame_done) fd_cnt++;
      end else begin
        nbits = 0;
      end
      prev_sclk  = led_sclk;
      prev_latch = led_latch;
    end
  end

  initial begin
    logic ok;
    logic [7:0] ls_pk;
    for (int i = 0; i < 32; i++) begin
      logic [4:0] av;
      av = 5'(i);
      ram[i] = {av, ~av, 1'b1, av};
    end
    // k is the cycle index after the first FETCH; one word spans 130 cycles,
    // one layer 525 cycles, one frame 2101 cycles.
    //        k     addr  cs sclk sd lat oe  ls  fd
    vt[0]  = '{0,    5'd0,  1, 0, 0, 0, 1, 2'd0, 0};
    vt[1]  = '{1,    5'd0,  0, 0, 0, 0, 1, 2'd0, 0};
    vt[2]  = '{2,    5'd0,  0, 0, 0, 0, 1, 2'd0, 0};
    vt[3]  = '{41,   5'd0,  0, 1, 0, 0, 1, 2'd0, 0};
    vt[4]  = '{42,   5'd0,  0, 0, 1, 0, 1, 2'd0, 0};
    vt[5]  = '{46,   5'd0,  0, 1, 1, 0, 1, 2'd0, 0};
    vt[6]  = '{129,  5'd0,  0, 1, 0, 0, 1, 2'd0, 0};
    vt[7]  = '{130,  5'd1,  1, 0, 0, 0, 1, 2'd0, 0};
    vt[8]  = '{164,  5'd1,  0, 0, 1, 0, 1, 2'd0, 0};
    vt[9]  = '{520,  5'd3,  0, 0, 0, 0, 1, 2'd0, 0};
    vt[10] = '{524,  5'd3,  0, 0, 0, 1, 1, 2'd0, 0};
    vt[11] = '{525,  5'd4,  1, 0, 0, 0, 0, 2'd0, 0};
    vt[12] = '{1049, 5'd7,  0, 0, 0, 1, 1, 2'd0, 0};
    vt[13] = '{1050, 5'd8,  1, 0, 0, 0, 0, 2'd1, 0};
    vt[14] = '{2099, 5'd15, 0, 0, 0, 1, 1, 2'd2, 0};
    vt[15] = '{2100, 5'd12, 0, 0, 0, 0, 0, 2'd3, 1};
    vt[16] = '{2101, 5'd0,  1, 0, 0, 0, 0, 2'd3, 0};

    reset_n = 1'b0; enable = 1'b0; swap_req = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_values", {17'd0, pack_all()}, {17'd0, c_RST_EXP});
    reset_n = 1'b1;
    @(negedge clk);
    chk("idle_no_fetch", {30'd0, mem_chipselect, led_oe_n}, 32'd1);

    sb_en = 1'b1;
    enable = 1'b1;
    k = -1;
    for (int i = 0; i < NV; i++) begin
      while (k < vt[i].k) tick();
      chk($sformatf("vec%0d_k%0d", i, vt[i].k),
          {19'd0, mem_address, mem_chipselect, led_sclk, led_sdata, led_latch, led_oe_n, layer_sel, frame_done},
          {19'd0, vt[i].addr, vt[i].cs, vt[i].sclk, vt[i].sdata, vt[i].latch, vt[i].oe_n, vt[i].ls, vt[i].fd});
    end

    ls_pk = (ls_log.size() == 4) ? {ls_log[3], ls_log[2], ls_log[1], ls_log[0]} : 8'h00;
    chk("frame1_latch_fd_count", {8'(latch_cnt), 8'(fd_cnt)}, {8'd4, 8'd1});
    chk("frame1_layer_sel_seq", {8'(ls_log.size()), ls_pk}, {8'd4, 8'hE4});

    // Swap requested mid-layer 1 of frame 2; only honoured at FRAME_END.
    ok = 1'b1;
    while (k < 4201) begin
      tick();
      if (k == 2826) swap_req = 1'b1;
      if (k < 4201 && (swap_ack || front_bank)) ok = 1'b0;
    end
    chk("no_early_swap", {31'd0, ok}, 32'd1);
    chk("frame_end_swap", {29'd0, swap_ack, frame_done, front_bank}, 32'b110);
    tick();
    chk("swap_first_fetch", {24'd0, front_bank, swap_ack, mem_chipselect, mem_address},
        {24'd0, 1'b1, 1'b0, 1'b1, 5'h10});
    swap_req = 1'b0;
    latch_cnt = 0; fd_cnt = 0;

    // Enable dropped mid-layer 1 of frame 3: the frame still completes.
    while (k < 6302) begin
      tick();
      if (k == 4827) enable = 1'b0;
    end
    chk("last_frame_done", {31'd0, frame_done}, 32'd1);
    tick();
    chk("idle_after_drop", {14'd0, 8'(latch_cnt), 8'(fd_cnt), mem_chipselect, led_oe_n},
        {14'd0, 8'd4, 8'd1, 1'b0, 1'b1});
    ok = 1'b1;
    repeat (300) begin
      tick();
      if (mem_chipselect || !led_oe_n || led_latch || frame_done) ok = 1'b0;
    end
    chk("idle_quiet", {31'd0, ok}, 32'd1);
    chk("sb_word_count", 32'(sb_words), 32'd48);
    chk("sb_queue_empty", 32'(addr_q.size()), 32'd0);
    sb_en = 1'b0;

    // Restart on the swapped bank, then reset in the middle of SHIFT.
    enable = 1'b1;
    k = -1;
    tick();
    chk("restart_fetch", {26'd0, mem_chipselect, mem_address}, {26'd0, 1'b1, 5'h10});
    while (k < 6) tick();
    chk("pre_reset_shift", {30'd0, led_sclk, led_sdata}, 32'b11);
    reset_n = 1'b0;
    #1;
    chk("reset_mid_shift", {17'd0, pack_all()}, {17'd0, c_RST_EXP});
    repeat (2) @(negedge clk);
    chk("reset_hold", {17'd0, pack_all()}, {17'd0, c_RST_EXP});
    reset_n = 1'b1;
    @(negedge clk);
    chk("post_reset_fetch", {25'd0, front_bank, mem_chipselect, mem_address},
        {25'd0, 1'b0, 1'b1, 5'h00});

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
